// File: rtl/next_pc_pkg.sv
// next_pc_pkg: shared width default, flow-op encoding and FSM states for the next-address stage
package next_pc_pkg;
    localparam int AW = 4;
    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BEQZ = 3'd2;
    localparam logic [2:0] OP_BNEZ = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    typedef enum logic {S_RUN, S_HALT} state_t;
endpackage

// File: rtl/next_pc_ctrl_if.sv
// next_pc_ctrl_if: pc/op/target request bundle and next-address/status response
interface next_pc_ctrl_if #(parameter int AW = next_pc_pkg::AW);
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    logic [AW-1:0] next;
    logic [2:0]    op;
    logic          zero;
    logic          stall;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_err;
    logic          halted;
    modport master (output pc, op, target, zero, stall, input next, ras_empty, ras_full, ras_err, halted);
    modport slave  (input pc, op, target, zero, stall, output next, ras_empty, ras_full, ras_err, halted);
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: LIFO of return addresses; push-when-full and pop-when-empty are ignored
module return_addr_stack #(
    parameter int AW = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);
    localparam int IW = $clog2(RAS_DEPTH);
    localparam int SW = IW + 1;
    logic [SW-1:0] sp;
    logic [AW-1:0] mem [RAS_DEPTH];
    logic [SW-1:0] sp_dec;
    assign sp_dec = sp - 1'b1;
    assign top    = mem[sp_dec[IW-1:0]];
    assign empty  = sp == '0;
    assign full   = sp == SW'(RAS_DEPTH);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[sp[IW-1:0]] <= din;
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end
endmodule

// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl: next-address mux with return-address stack, sticky stack error and RUN/HALT FSM
module next_pc_ctrl import next_pc_pkg::*; #(
    parameter int AW = next_pc_pkg::AW,
    parameter int RAS_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    next_pc_ctrl_if.slave bus
);
    state_t        state;
    logic          err;
    logic          run;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic [AW-1:0] inc;
    logic [AW-1:0] top;
    assign run  = state == S_RUN && !bus.stall;
    assign inc  = bus.pc + 1'b1;
    assign push = run && bus.op == OP_CALL && !full;
    assign pop  = run && bus.op == OP_RET && !empty;
    return_addr_stack #(.AW(AW), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(inc),
        .top(top), .empty(empty), .full(full)
    );
    // Suppressed CALL/RET fall through to inc; HALT and stall hold pc.
    always_comb begin
        bus.next = rst ? '0 :
                   !run ? bus.pc :
                   bus.op == OP_JMP  ? bus.target :
                   bus.op == OP_BEQZ ? (bus.zero ? bus.target : inc) :
                   bus.op == OP_BNEZ ? (bus.zero ? inc : bus.target) :
                   push ? bus.target :
                   pop ? top :
                   bus.op == OP_HALT ? bus.pc : inc;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            err   <= 1'b0;
        end else begin
            if (run && bus.op == OP_HALT) state <= S_HALT;
            if (run && ((bus.op == OP_CALL && full) || (bus.op == OP_RET && empty))) err <= 1'b1;
        end
    end
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_err   = err;
    assign bus.halted    = state == S_HALT;
endmodule

// File: tb/tb_next_pc_ctrl.sv
// tb_next_pc_ctrl: directed per-feature checks of next-address, RAS flags and HALT behaviour
module tb_next_pc_ctrl;
    import next_pc_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    next_pc_ctrl_if #(.AW(4)) bus ();
    next_pc_ctrl #(.AW(4), .RAS_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] o, input logic [3:0] p, input logic [3:0] t, input logic z, input logic s);
        bus.op = o; bus.pc = p; bus.target = t; bus.zero = z; bus.stall = s;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(OP_JMP, 4'd5, 4'd9, 1'b0, 1'b0);
        tests++;
        if ({bus.next, bus.halted, bus.ras_err, bus.ras_empty, bus.ras_full} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got next=%0d h=%b e=%b em=%b fu=%b, expected 0 0 0 1 0",
                     bus.next, bus.halted, bus.ras_err, bus.ras_empty, bus.ras_full);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_seq_wrap();
        logic [3:0] p = 4'd0;
        for (int i = 0; i < 16; i++) begin
            drive(OP_SEQ, p, 4'd0, 1'b0, 1'b0);
            tests++;
            if (bus.next !== 4'((i + 1) % 16) || {bus.halted, bus.ras_err, bus.ras_full, bus.ras_empty} !== 4'b0001) begin
                fails++;
                $display("FAIL seq_%0d: got next=%0d flags=%b, expected next=%0d flags=0001",
                         i, bus.next, {bus.halted, bus.ras_err, bus.ras_full, bus.ras_empty}, (i + 1) % 16);
            end
            p = bus.next;
            tick();
        end
        drive(3'd7, 4'd6, 4'd2, 1'b0, 1'b0);
        tests++;
        if (bus.next !== 4'd7) begin fails++; $display("FAIL reserved_op: got %0d expected 7", bus.next); end
        tick();
    endtask

    task automatic test_branches();
        logic [2:0]  o [5] = '{OP_BEQZ, OP_BEQZ, OP_BNEZ, OP_BNEZ, OP_JMP};
        logic        z [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  e [5] = '{4'd9, 4'd4, 4'd9, 4'd4, 4'd9};
        for (int i = 0; i < 5; i++) begin
            drive(o[i], 4'd3, 4'd9, z[i], 1'b0);
            tests++;
            if (bus.next !== e[i]) begin fails++; $display("FAIL branch_%0d: got %0d expected %0d", i, bus.next, e[i]); end
            tick();
        end
    endtask

    task automatic test_call_ret();
        logic [2:0] o [4] = '{OP_CALL, OP_CALL, OP_RET, OP_RET};
        logic [3:0] p [4] = '{4'd2, 4'd9, 4'd12, 4'd10};
        logic [3:0] t [4] = '{4'd8, 4'd12, 4'd0, 4'd0};
        logic [3:0] e [4] = '{4'd8, 4'd12, 4'd10, 4'd3};
        for (int i = 0; i < 4; i++) begin
            drive(o[i], p[i], t[i], 1'b0, 1'b0);
            tests++;
            if (bus.next !== e[i]) begin fails++; $display("FAIL call_ret_%0d: got %0d expected %0d", i, bus.next, e[i]); end
            tick();
        end
        tests++;
        if (bus.ras_empty !== 1'b1 || bus.ras_err !== 1'b0) begin
            fails++;
            $display("FAIL call_ret_flags: got empty=%b err=%b expected 1 0", bus.ras_empty, bus.ras_err);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            drive(OP_CALL, 4'(i), 4'(i + 8), 1'b0, 1'b0);
            tests++;
            if (bus.next !== 4'(i + 8)) begin fails++; $display("FAIL fill_%0d: got %0d expected %0d", i, bus.next, i + 8); end
            tick();
        end
        tests++;
        if (bus.ras_full !== 1'b1 || bus.ras_err !== 1'b0) begin
            fails++;
            $display("FAIL full_flag: got full=%b err=%b expected 1 0", bus.ras_full, bus.ras_err);
        end
        drive(OP_CALL, 4'd5, 4'd1, 1'b0, 1'b0);
        tests++;
        if (bus.next !== 4'd6) begin fails++; $display("FAIL overflow_next: got %0d expected 6", bus.next); end
        tick();
        tests++;
        if (bus.ras_err !== 1'b1 || bus.ras_full !== 1'b1) begin
            fails++;
            $display("FAIL overflow_flags: got err=%b full=%b expected 1 1", bus.ras_err, bus.ras_full);
        end
        for (int i = 0; i < 4; i++) begin
            drive(OP_RET, 4'd15, 4'd0, 1'b0, 1'b0);
            tests++;
            if (bus.next !== 4'(4 - i)) begin fails++; $display("FAIL unwind_%0d: got %0d expected %0d", i, bus.next, 4 - i); end
            tick();
        end
        drive(OP_RET, 4'd7, 4'd0, 1'b0, 1'b0);
        tests++;
        if (bus.next !== 4'd8) begin fails++; $display("FAIL underflow_next: got %0d expected 8", bus.next); end
        tick();
        tests++;
        if (bus.ras_err !== 1'b1 || bus.ras_empty !== 1'b1) begin
            fails++;
            $display("FAIL underflow_flags: got err=%b empty=%b expected 1 1", bus.ras_err, bus.ras_empty);
        end
    endtask

    task automatic test_stall_halt();
        drive(OP_JMP, 4'd2, 4'd5, 1'b0, 1'b1);
        tests++;
        if (bus.next !== 4'd2) begin fails++; $display("FAIL stall_jmp: got %0d expected 2", bus.next); end
        tick();
        drive(OP_CALL, 4'd2, 4'd5, 1'b0, 1'b1);
        tick();
        tests++;
        if (bus.ras_empty !== 1'b1) begin fails++; $display("FAIL stall_call_push: got empty=%b expected 1", bus.ras_empty); end
        drive(OP_HALT, 4'd4, 4'd0, 1'b0, 1'b1);
        tick();
        tests++;
        if (bus.halted !== 1'b0) begin fails++; $display("FAIL stalled_halt: got halted=%b expected 0", bus.halted); end
        drive(OP_HALT, 4'd4, 4'd0, 1'b0, 1'b0);
        tests++;
        if (bus.next !== 4'd4 || bus.halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_next: got next=%0d halted=%b expected 4 0", bus.next, bus.halted);
        end
        tick();
        tests++;
        if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_enter: got halted=%b expected 1", bus.halted); end
        drive(OP_JMP, 4'd4, 4'd0, 1'b0, 1'b0);
        tests++;
        if (bus.next !== 4'd4) begin fails++; $display("FAIL halted_jmp: got %0d expected 4", bus.next); end
        tick();
        drive(OP_CALL, 4'd4, 4'd9, 1'b0, 1'b0);
        tests++;
        if (bus.next !== 4'd4) begin fails++; $display("FAIL halted_call: got %0d expected 4", bus.next); end
        tick();
        tests++;
        if (bus.halted !== 1'b1 || bus.ras_empty !== 1'b1) begin
            fails++;
            $display("FAIL halted_hold: got halted=%b empty=%b expected 1 1", bus.halted, bus.ras_empty);
        end
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(OP_RET, 4'd1, 4'd0, 1'b0, 1'b0);
        tick();
        drive(OP_CALL, 4'd1, 4'd6, 1'b0, 1'b0);
        tick();
        drive(OP_CALL, 4'd6, 4'd11, 1'b0, 1'b0);
        tick();
        drive(OP_HALT, 4'd11, 4'd0, 1'b0, 1'b0);
        tick();
        tests++;
        if ({bus.halted, bus.ras_err, bus.ras_empty} !== 3'b110) begin
            fails++;
            $display("FAIL pre_reset_state: got h/e/em=%b expected 110", {bus.halted, bus.ras_err, bus.ras_empty});
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus.next, bus.halted, bus.ras_err, bus.ras_empty} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL async_reset: got next=%0d h=%b e=%b em=%b expected 0 0 0 1",
                     bus.next, bus.halted, bus.ras_err, bus.ras_empty);
        end
        rst = 1'b0;
        drive(OP_RET, 4'd6, 4'd0, 1'b0, 1'b0);
        tests++;
        if (bus.next !== 4'd7) begin fails++; $display("FAIL post_reset_ret: got %0d expected 7", bus.next); end
        tick();
        tests++;
        if (bus.ras_err !== 1'b1 || bus.halted !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_flags: got err=%b halted=%b expected 1 0", bus.ras_err, bus.halted);
        end
    endtask

    initial begin
        bus.op = OP_SEQ; bus.pc = '0; bus.target = '0; bus.zero = 1'b0; bus.stall = 1'b0;
        test_reset();
        test_seq_wrap();
        test_branches();
        test_call_ret();
        test_overflow();
        test_stall_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
